// File: rtl/plc_io_pkg.sv
// Shared defaults and filter-state type for the PLC GPIO boundary bridge.
// The optional link watchdog is built only when PLC_IO_WDT_EN is defined.
package plc_io_pkg;

    localparam int DEF_N_Q       = 11;
    localparam int DEF_N_I       = 14;
    localparam int DEF_FILT_LEN  = 4;
    localparam int DEF_PWM_W     = 16;
    localparam int DEF_WDT_TICKS = 200;

    // Counter width is fixed so the state type stays parameter-free; FILT_LEN up to 256.
    localparam int FILT_CNT_W = 8;

    typedef struct packed {
        logic                  level;
        logic [FILT_CNT_W-1:0] cnt;
    } filt_state_t;

endpackage

// File: rtl/plc_io_bridge_if.sv
// Signal bundle between the GPIO/plant side and plc_io_bridge.
// Used unchanged whether or not PLC_IO_WDT_EN is defined.
interface plc_io_bridge_if
    import plc_io_pkg::*;
#(
    parameter int N_Q   = DEF_N_Q,
    parameter int N_I   = DEF_N_I,
    parameter int PWM_W = DEF_PWM_W
) ();

    logic             en;
    logic             manual;
    logic [N_Q-1:0]   man_q;
    logic [N_Q-1:0]   q_raw;
    logic             pwm_raw;
    logic [N_Q-1:0]   q_out;
    logic [PWM_W-1:0] pwm_duty;
    logic             pwm_valid;
    logic [N_I-1:0]   i_in;
    logic [N_I-1:0]   i_out;
    logic             link_ok;

    modport master (
        output en, manual, man_q, q_raw, pwm_raw, i_in,
        input  q_out, pwm_duty, pwm_valid, i_out, link_ok
    );

    modport slave (
        input  en, manual, man_q, q_raw, pwm_raw, i_in,
        output q_out, pwm_duty, pwm_valid, i_out, link_ok
    );

endinterface

// File: rtl/plc_io_filter.sv
// One PLC output channel: two-flop synchroniser followed by an en-sampled glitch filter.
// The synchronised level is exported only when PLC_IO_WDT_EN is defined.
module plc_io_filter
    import plc_io_pkg::*;
#(
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_raw,
`ifdef PLC_IO_WDT_EN
    output logic o_sync,
`endif
    output logic o_level
);

    localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

    logic        r_s1;
    logic        r_s2;
    filt_state_t r_state;

    // NOTE: non-blocking assignments on every flop so each one samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (i_en) begin
                if (r_s2 == r_state.level) begin
                    r_state.cnt <= '0;
                end else if (r_state.cnt == CNT_LAST) begin
                    r_state.level <= r_s2;
                    r_state.cnt   <= '0;
                end else begin
                    r_state.cnt <= r_state.cnt + 1'b1;
                end
            end
        end
    end

`ifdef PLC_IO_WDT_EN
    assign o_sync = r_s2;
`endif
    assign o_level = r_state.level;

endmodule

// File: rtl/plc_io_bridge.sv
// PLC GPIO boundary: filtered/overridable commands, PWM duty decode, sensor return path.
// Define PLC_IO_WDT_EN to build the link watchdog; otherwise link_ok is 1 after reset.
module plc_io_bridge
    import plc_io_pkg::*;
#(
    parameter int N_Q       = DEF_N_Q,
    parameter int N_I       = DEF_N_I,
    parameter int FILT_LEN  = DEF_FILT_LEN,
    parameter int PWM_W     = DEF_PWM_W,
    parameter int WDT_TICKS = DEF_WDT_TICKS
) (
    input  logic           clk,
    input  logic           rst_n,
    plc_io_bridge_if.slave bus
);

    logic [N_Q-1:0]   w_filt;
    logic             r_pwm_s1;
    logic             r_pwm_s2;
    logic [PWM_W-1:0] r_win_cnt;
    logic [PWM_W-1:0] r_high_cnt;
    logic [PWM_W-1:0] w_high_next;
    logic [PWM_W-1:0] r_pwm_duty;
    logic             r_pwm_valid;
    logic [N_Q-1:0]   r_q_out;
    logic [N_I-1:0]   r_i_out;
    logic             r_link_ok;

`ifdef PLC_IO_WDT_EN
    logic [N_Q-1:0] w_sync;
`endif

    for (genvar g = 0; g < N_Q; g++) begin : g_chan
        plc_io_filter #(
            .FILT_LEN (FILT_LEN)
        ) u_filter (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (bus.en),
            .i_raw   (bus.q_raw[g]),
`ifdef PLC_IO_WDT_EN
            .o_sync  (w_sync[g]),
`endif
            .o_level (w_filt[g])
        );
    end

    // NOTE: default assigned first so no path through always_comb can infer a latch.
    always_comb begin
        w_high_next = r_high_cnt;
        if (r_pwm_s2 && (r_high_cnt != '1)) begin
            w_high_next = r_high_cnt + 1'b1;
        end
    end

    // The last window cycle's own sample is folded into the published duty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_s1    <= 1'b0;
            r_pwm_s2    <= 1'b0;
            r_win_cnt   <= '0;
            r_high_cnt  <= '0;
            r_pwm_duty  <= '0;
            r_pwm_valid <= 1'b0;
        end else begin
            r_pwm_s1    <= bus.pwm_raw;
            r_pwm_s2    <= r_pwm_s1;
            r_win_cnt   <= r_win_cnt + 1'b1;
            r_pwm_valid <= 1'b0;
            if (r_win_cnt == '1) begin
                r_pwm_duty  <= w_high_next;
                r_pwm_valid <= 1'b1;
                r_high_cnt  <= '0;
            end else begin
                r_high_cnt <= w_high_next;
            end
        end
    end

`ifdef PLC_IO_WDT_EN
    localparam int WDT_W = $clog2(WDT_TICKS + 1);
    localparam logic [WDT_W-1:0] WDT_MAX  = WDT_W'(WDT_TICKS);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TICKS - 1);

    logic [N_Q-1:0]   r_q_prev;
    logic             r_pwm_prev;
    logic [WDT_W-1:0] r_wdt_cnt;
    logic             w_activity;

    assign w_activity = (w_sync != r_q_prev) || (r_pwm_s2 != r_pwm_prev);

    // Activity takes priority over a coincident en tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_prev   <= '0;
            r_pwm_prev <= 1'b0;
            r_wdt_cnt  <= '0;
            r_link_ok  <= 1'b0;
        end else begin
            r_q_prev   <= w_sync;
            r_pwm_prev <= r_pwm_s2;
            if (w_activity) begin
                r_wdt_cnt <= '0;
                r_link_ok <= 1'b1;
            end else if (bus.en && (r_wdt_cnt != WDT_MAX)) begin
                r_wdt_cnt <= r_wdt_cnt + 1'b1;
                if (r_wdt_cnt == WDT_LAST) begin
                    r_link_ok <= 1'b0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_link_ok <= 1'b0;
        end else begin
            r_link_ok <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_out <= '0;
            r_i_out <= '0;
        end else begin
            r_q_out <= bus.manual ? bus.man_q : (r_link_ok ? w_filt : '0);
            r_i_out <= bus.i_in;
        end
    end

    assign bus.q_out     = r_q_out;
    assign bus.pwm_duty  = r_pwm_duty;
    assign bus.pwm_valid = r_pwm_valid;
    assign bus.i_out     = r_i_out;
    assign bus.link_ok   = r_link_ok;

endmodule

// File: tb/tb_plc_io_bridge.sv
// Directed bench for plc_io_bridge (PWM_W=8, WDT_TICKS=5); expectations follow PLC_IO_WDT_EN.
module tb_plc_io_bridge;
    import plc_io_pkg::*;

    localparam int N_Q       = 11;
    localparam int N_I       = 14;
    localparam int FILT_LEN  = 4;
    localparam int PWM_W     = 8;
    localparam int WDT_TICKS = 5;
`ifdef PLC_IO_WDT_EN
    localparam bit WDT = 1'b1;
`else
    localparam bit WDT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pwm_mode = 0;   // 0: 4 high of 16, 1: stuck high
    int   cyc;

    plc_io_bridge_if #(.N_Q(N_Q), .N_I(N_I), .PWM_W(PWM_W)) bus ();

    plc_io_bridge #(
        .N_Q       (N_Q),
        .N_I       (N_I),
        .FILT_LEN  (FILT_LEN),
        .PWM_W     (PWM_W),
        .WDT_TICKS (WDT_TICKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One en pulse followed by nine idle cycles (10-clk strobe period).
    task automatic strobes(input int n);
        repeat (n) begin
            bus.en = 1'b1;
            tick(1);
            bus.en = 1'b0;
            tick(9);
        end
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.pwm_valid && cycles < 400);
    endtask

    initial begin : pwm_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            bus.pwm_raw = (pwm_mode == 1) ? 1'b1 : (ph < 4);
            ph = (ph + 1) % 16;
        end
    end

    initial begin : timeout
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.en      = 1'b0;
        bus.manual  = 1'b1;
        bus.man_q   = 11'h7FF;
        bus.q_raw   = '0;
        bus.pwm_raw = 1'b0;
        bus.i_in    = 14'h3FFF;

        tick(3);
        check("reset q_out",     bus.q_out,     0);
        check("reset pwm_duty",  bus.pwm_duty,  0);
        check("reset pwm_valid", bus.pwm_valid, 0);
        check("reset i_out",     bus.i_out,     0);
        check("reset link_ok",   bus.link_ok,   0);

        bus.manual = 1'b0;
        bus.i_in   = '0;
        rst_n      = 1'b1;

        wait_valid(cyc);
        check("first pwm_valid delay", cyc, 256);
        wait_valid(cyc);
        check("pwm_valid period", cyc, 256);
        check("pwm_duty 25%", bus.pwm_duty, 64);
        tick(1);
        check("pwm_valid one cycle", bus.pwm_valid, 0);
        check("link_ok up", bus.link_ok, 1);

        bus.q_raw[0] = 1'b1;
        tick(3);
        strobes(3);
        check("q_out before 4th en", bus.q_out, 11'h000);
        bus.en = 1'b1;
        tick(1);
        bus.en = 1'b0;
        check("q_out at 4th en edge", bus.q_out, 11'h000);
        tick(1);
        check("q_out one clk after 4th en", bus.q_out, 11'h001);
        tick(8);

        bus.en = 1'b1;
        tick(1);
        bus.en = 1'b0;
        bus.q_raw[3] = 1'b1;
        tick(5);
        check("q_out during glitch", bus.q_out, 11'h001);
        bus.q_raw[3] = 1'b0;
        tick(4);
        strobes(4);
        check("q_out after glitch", bus.q_out, 11'h001);

        bus.manual = 1'b1;
        bus.man_q  = 11'h555;
        bus.q_raw  = 11'h7FE;
        tick(1);
        check("manual man_q 555", bus.q_out, 11'h555);
        bus.man_q = 11'h2AA;
        tick(1);
        check("manual man_q 2AA", bus.q_out, 11'h2AA);
        bus.q_raw  = 11'h001;
        bus.manual = 1'b0;
        tick(1);
        check("manual off restores filt", bus.q_out, 11'h001);

        bus.i_in = 14'h2AAA;
        tick(1);
        check("i_out 2AAA", bus.i_out, 14'h2AAA);
        bus.i_in = 14'h1555;
        tick(1);
        check("i_out 1555", bus.i_out, 14'h1555);

        bus.q_raw[0] = 1'b0;
        tick(3);
        strobes(3);
        check("fall after 3 en", bus.q_out, 11'h001);
        bus.q_raw[0] = 1'b1;
        tick(3);
        strobes(1);
        bus.q_raw[0] = 1'b0;
        tick(3);
        strobes(3);
        check("count cleared by matching sample", bus.q_out, 11'h001);
        strobes(1);
        check("fall after 4 en", bus.q_out, 11'h000);

        pwm_mode = 1;
        wait_valid(cyc);
        check("pwm_valid seen after stuck", bus.pwm_valid, 1);
        wait_valid(cyc);
        check("pwm_valid period stuck", cyc, 256);
        check("pwm_duty saturated", bus.pwm_duty, 255);

        bus.q_raw[5] = 1'b1;
        tick(3);
        strobes(4);
        check("q_out ch5 filtered", bus.q_out, 11'h020);
        check("link_ok after 4 idle en", bus.link_ok, 1);
        bus.en = 1'b1;
        tick(1);
        bus.en = 1'b0;
        check("link_ok at 5th idle en", bus.link_ok, WDT ? 0 : 1);
        tick(1);
        check("q_out while link lost", bus.q_out, WDT ? 11'h000 : 11'h020);
        bus.i_in = 14'h3C3C;
        tick(1);
        check("i_out while link lost", bus.i_out, 14'h3C3C);
        bus.q_raw[1] = 1'b1;
        tick(5);
        check("link_ok after q edge", bus.link_ok, 1);
        check("q_out after relink", bus.q_out, 11'h020);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/plc_io_bridge.md
# plc_io_bridge

Parametrised boundary block between the OpenPLC/Raspberry Pi GPIO link and the plant simulation, generalising the fixed per-pin glue of the bakery top level. It synchronises and glitch-filters N_Q PLC output bits, applies a manual-override mux, decodes the analog PWM channel into a duty value, registers N_I plant sensor bits back to the PLC, and runs a link watchdog that fails the plant inputs safe when the PLC goes silent.

## Interface
- N_Q, 11: PLC output channels (inputs here)
- N_I, 14: PLC input channels (outputs here)
- FILT_LEN, 4: consecutive differing `en` samples needed to accept a new level (≥1)
- PWM_W, 16: PWM measurement window is 2^PWM_W clk cycles; duty width
- WDT_TICKS, 200: `en` ticks without PLC activity before link loss (≥1)

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- en  in  1  sample strobe, one-cycle pulse (rate limiter output)
- manual  in  1  manual mode select
- man_q  in  N_Q  manual values for the plant inputs
- q_raw  in  N_Q  asynchronous PLC outputs from GPIO
- pwm_raw  in  1  asynchronous PLC PWM output
- q_out  out  N_Q  filtered/muxed PLC commands to the plant
- pwm_duty  out  PWM_W  high-cycle count of last complete window
- pwm_valid  out  1  one-cycle pulse when pwm_duty updates
- i_in  in  N_I  plant sensor bits
- i_out  out  N_I  registered sensor bits to GPIO
- link_ok  out  1  PLC activity seen within the watchdog window

## Operation
- Reset: all sync flops, filter state, counters, q_out, pwm_duty, pwm_valid, i_out, link_ok = 0.
- Sync: q_raw and pwm_raw pass through two flops each (s1, s2) every clk.
- Filter per channel: state filt, counter cnt. On en: if s2 == filt, cnt ← 0; else if cnt == FILT_LEN-1, filt ← s2, cnt ← 0; else cnt ← cnt+1. No change when en = 0.
- q_out register, every clk: manual ? man_q : (link_ok ? filt : 0).
- PWM: free-running window counter over 2^PWM_W clk cycles; high counter increments on each clk with s2(pwm)=1, saturating at 2^PWM_W−1. On the last window cycle: pwm_duty ← final count (including that cycle), pwm_valid = 1, high counter restarts at that cycle's next value 0.
- Watchdog: activity = any edge on synced q bits (s2 vs. previous s2) or synced pwm. Activity clears tick counter and sets link_ok next clk. Otherwise on en, counter increments, saturating at WDT_TICKS; link_ok ← 0 when counter reaches WDT_TICKS.
- Simultaneous activity and en: activity wins (counter cleared).
- i_out ← i_in every clk, independent of manual and link_ok.

## Timing
- q_raw change to s2: 2 clk. s2 to filt: FILT_LEN en strobes of stable differing level. filt to q_out: 1 clk.
- manual toggle to q_out: 1 clk; man_q to q_out: 1 clk.
- Single-sample glitch (shorter than one en period) never reaches q_out.
- i_in to i_out: 1 clk.
- Reset mid-filter or mid-window discards partial counts; first pwm_valid 2^PWM_W clk after reset release.

## Configuration
- PLC_IO_WDT_EN defined: watchdog as above.
- Undefined: no watchdog logic; link_ok is constant 1 after reset, q_out never forced to 0.

## Structure
- Package plc_io_pkg: default parameter constants (N_Q, N_I, FILT_LEN, PWM_W, WDT_TICKS) and the filter-state typedef.
- Sub-module plc_io_filter: one channel of 2-flop sync + filter, instantiated N_Q times via generate.

## Test plan
- Reset then q_raw[0]=1 held, en every 10 clk, FILT_LEN=4 -> q_out[0] rises 1 clk after 4th en strobe past s2; before that q_out=0.
- q_raw[3] pulse of 5 clk between en strobes -> q_out[3] stays 0.
- manual=1, man_q=11'h555 -> q_out=11'h555 next clk regardless of q_raw; manual=0 -> q_out returns to filt next clk.
- PWM_W=8, pwm_raw 25% duty with 16-clk period -> pwm_valid every 256 clk, pwm_duty=64 (±1 on phase); pwm_raw stuck high -> pwm_duty=255.
- With PLC_IO_WDT_EN, WDT_TICKS=5, no edges after link up -> link_ok falls at 5th en, q_out=0; single q_raw edge -> link_ok=1 and q_out=filt again.
- i_in=14'h2AAA -> i_out=14'h2AAA one clk later, also while link_ok=0.
